// File: rtl/lsu_tlb_rd_ctl.sv
// -----------------------------------------------------------------------------
// lsu_tlb_rd_ctl
//
// Sequencer and arbiter for ASI diagnostic reads of the DTLB (tag, data and
// CSM views). Picks one requesting thread round-robin and issues the array
// read with the matching format selects. After RD_LAT cycles it captures the
// formatted read word and the relevant parity-check result. It returns them
// to the owning thread through a ready/valid response port.
//
// Ports
//   rclk, rst_l              clock, asynchronous active-low reset
//   req_vld/req_idx/req_type per-thread level requests (thread t at slice t)
//   req_ack                  one-hot acceptance pulse (issued in the RD cycle)
//   stall                    TLB busy; only blocks new grants
//   tlb_rd_vld/tlb_rd_idx    array read strobe and index
//   lsu_tlb_data_rd_vld_g    data-view format select (RD..CAPT)
//   lsu_tlb_csm_rd_vld_g     CSM-view format select  (RD..CAPT)
//   lsu_tlb_rd_data          formatted read word from the array datapath
//   tte_*_parity_error       parity-check results for the current read
//   rsp_vld/rsp_rdy          response handshake
//   rsp_tid/rsp_data/rsp_perr response payload, stable while rsp_vld
// -----------------------------------------------------------------------------
module lsu_tlb_rd_ctl #(
   parameter int NTHR   = 4,
   parameter int TID_W  = 2,
   parameter int IDX_W  = 6,
   parameter int RD_LAT = 2
) (
   input  logic                    rclk,
   input  logic                    rst_l,
   input  logic [NTHR-1:0]         req_vld,
   input  logic [NTHR*IDX_W-1:0]   req_idx,
   input  logic [NTHR*2-1:0]       req_type,
   output logic [NTHR-1:0]         req_ack,
   input  logic                    stall,
   output logic                    tlb_rd_vld,
   output logic [IDX_W-1:0]        tlb_rd_idx,
   output logic                    lsu_tlb_data_rd_vld_g,
   output logic                    lsu_tlb_csm_rd_vld_g,
   input  logic [63:0]             lsu_tlb_rd_data,
   input  logic                    tte_tag_parity_error,
   input  logic                    tte_data_parity_error,
   output logic                    rsp_vld,
   input  logic                    rsp_rdy,
   output logic [TID_W-1:0]        rsp_tid,
   output logic [63:0]             rsp_data,
   output logic                    rsp_perr
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, CAPT, RESP} state_t;

   // WAIT lasts RD_LAT-1 cycles: the counter is loaded with RD_LAT-2 and
   // exits on zero. With RD_LAT==1 the WAIT state is never entered.
   localparam int WAIT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;
   localparam int CNT_W     = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;

   localparam logic [1:0] TYPE_DATA = 2'b01;
   localparam logic [1:0] TYPE_CSM  = 2'b10;

   state_t             state;
   logic [TID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   cnt;
   logic [TID_W-1:0]   tid_q;
   logic [IDX_W-1:0]   idx_q;
   logic [1:0]         type_q;

   logic               gnt_vld;
   logic [TID_W-1:0]   gnt_tid;
   logic               perr_sel;
   logic               rd_busy;

   // Round-robin pick: first requester at or after rr_ptr. Scanning from the
   // farthest offset down lets the nearest requester overwrite the result.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_tid = rr_ptr;
      for (int i = NTHR - 1; i >= 0; i--) begin
         if (req_vld[rr_ptr + TID_W'(i)]) begin
            gnt_vld = 1'b1;
            gnt_tid = rr_ptr + TID_W'(i);
         end
      end
   end

   // Parity result source: data view checks data parity, CSM has none, tag
   // and the reserved encoding 11 check tag parity.
   always_comb begin
      case (type_q)
         TYPE_DATA: perr_sel = tte_data_parity_error;
         TYPE_CSM:  perr_sel = 1'b0;
         default:   perr_sel = tte_tag_parity_error;
      endcase
   end

   // NOTE: state and payload registers use non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   // The payload registers are reset as well, so rsp_data reads 0 out of reset.
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         cnt      <= '0;
         tid_q    <= '0;
         idx_q    <= '0;
         type_q   <= '0;
         rsp_tid  <= '0;
         rsp_data <= '0;
         rsp_perr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld && !stall) begin
                  tid_q  <= gnt_tid;
                  idx_q  <= req_idx[gnt_tid*IDX_W +: IDX_W];
                  type_q <= req_type[gnt_tid*2 +: 2];
                  state  <= RD;
               end
            end
            RD: begin
               if (RD_LAT > 1) begin
                  cnt   <= CNT_W'(WAIT_LOAD);
                  state <= WAIT;
               end else begin
                  state <= CAPT;
               end
            end
            WAIT: begin
               if (cnt == '0) state <= CAPT;
               else           cnt   <= cnt - 1'b1;
            end
            CAPT: begin
               rsp_data <= lsu_tlb_rd_data;
               rsp_perr <= perr_sel;
               rsp_tid  <= tid_q;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_rdy) begin
                  // The thread just served drops to lowest priority.
                  rr_ptr <= tid_q + TID_W'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded from state plus latched registers, so an asynchronous
   // reset clears them in the same cycle.
   assign rd_busy               = (state == RD) || (state == WAIT) || (state == CAPT);
   assign tlb_rd_vld            = (state == RD);
   assign tlb_rd_idx            = (state == RD) ? idx_q : '0;
   assign lsu_tlb_data_rd_vld_g = rd_busy && (type_q == TYPE_DATA);
   assign lsu_tlb_csm_rd_vld_g  = rd_busy && (type_q == TYPE_CSM);
   assign rsp_vld               = (state == RESP);

   always_comb begin
      req_ack = '0;
      if (state == RD) req_ack[tid_q] = 1'b1;
   end

endmodule

// File: tb/tb_lsu_tlb_rd_ctl.sv
// -----------------------------------------------------------------------------
// tb_lsu_tlb_rd_ctl
//
// Directed bench for lsu_tlb_rd_ctl. Two instances share all inputs: dut with
// RD_LAT=2 and dut1 with RD_LAT=1. The bench counts cycles from the grant edge
// E0, so "cycle k" is the interval after edge Ek. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_lsu_tlb_rd_ctl;

   logic          rclk = 1'b0;
   logic          rst_l;
   logic [3:0]    req_vld;
   logic [23:0]   req_idx;
   logic [7:0]    req_type;
   logic          stall;
   logic [63:0]   rd_data;
   logic          tag_err;
   logic          data_err;
   logic          rsp_rdy;

   logic [3:0]    req_ack,  d1_req_ack;
   logic          rd_vld,   d1_rd_vld;
   logic [5:0]    rd_idx,   d1_rd_idx;
   logic          data_sel, d1_data_sel;
   logic          csm_sel,  d1_csm_sel;
   logic          rsp_vld,  d1_rsp_vld;
   logic [1:0]    rsp_tid,  d1_rsp_tid;
   logic [63:0]   rsp_data, d1_rsp_data;
   logic          rsp_perr, d1_rsp_perr;

   int checks   = 0;
   int failures = 0;

   always #5 rclk = ~rclk;

   lsu_tlb_rd_ctl #(.NTHR(4), .TID_W(2), .IDX_W(6), .RD_LAT(2)) dut (
      .rclk(rclk), .rst_l(rst_l), .req_vld(req_vld), .req_idx(req_idx),
      .req_type(req_type), .req_ack(req_ack), .stall(stall),
      .tlb_rd_vld(rd_vld), .tlb_rd_idx(rd_idx),
      .lsu_tlb_data_rd_vld_g(data_sel), .lsu_tlb_csm_rd_vld_g(csm_sel),
      .lsu_tlb_rd_data(rd_data), .tte_tag_parity_error(tag_err),
      .tte_data_parity_error(data_err), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
      .rsp_tid(rsp_tid), .rsp_data(rsp_data), .rsp_perr(rsp_perr)
   );

   lsu_tlb_rd_ctl #(.NTHR(4), .TID_W(2), .IDX_W(6), .RD_LAT(1)) dut1 (
      .rclk(rclk), .rst_l(rst_l), .req_vld(req_vld), .req_idx(req_idx),
      .req_type(req_type), .req_ack(d1_req_ack), .stall(stall),
      .tlb_rd_vld(d1_rd_vld), .tlb_rd_idx(d1_rd_idx),
      .lsu_tlb_data_rd_vld_g(d1_data_sel), .lsu_tlb_csm_rd_vld_g(d1_csm_sel),
      .lsu_tlb_rd_data(rd_data), .tte_tag_parity_error(tag_err),
      .tte_data_parity_error(data_err), .rsp_vld(d1_rsp_vld), .rsp_rdy(rsp_rdy),
      .rsp_tid(d1_rsp_tid), .rsp_data(d1_rsp_data), .rsp_perr(d1_rsp_perr)
   );

   wire [80:0] all_out    = {req_ack, rd_vld, rd_idx, data_sel, csm_sel,
                             rsp_vld, rsp_tid, rsp_data, rsp_perr};
   wire [80:0] d1_all_out = {d1_req_ack, d1_rd_vld, d1_rd_idx, d1_data_sel,
                             d1_csm_sel, d1_rsp_vld, d1_rsp_tid, d1_rsp_data,
                             d1_rsp_perr};

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic set_req(input int t, input logic [5:0] idx, input logic [1:0] typ);
      req_idx[t*6 +: 6]  = idx;
      req_type[t*2 +: 2] = typ;
   endtask

   // Leaves both instances in IDLE, 1 unit after an edge, with no requests.
   task automatic do_reset();
      rst_l    = 1'b0;
      req_vld  = '0;
      req_idx  = '0;
      req_type = '0;
      stall    = 1'b0;
      rd_data  = '0;
      tag_err  = 1'b0;
      data_err = 1'b0;
      rsp_rdy  = 1'b1;
      tick();
      tick();
      rst_l = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (all_out !== 81'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      checks++;
      if (d1_all_out !== 81'h0) begin
         failures++;
         $display("FAIL reset_outputs_lat1: got %h expected 0", d1_all_out);
      end
      // Thread 1 read, then reset lands in the WAIT cycle.
      set_req(1, 6'h2A, 2'b00);
      req_vld = 4'b0010;
      rd_data = 64'h0123_4567_89AB_CDEF;
      tick();              // cycle 1: RD
      tick();              // cycle 2: WAIT
      rst_l = 1'b0;
      #1;
      checks++;
      if (all_out !== 81'h0) begin
         failures++;
         $display("FAIL reset_mid_wait: got %h expected 0", all_out);
      end
      tick();
      rst_l = 1'b1;        // request still held: re-arbitrated
      tick();              // cycle 1
      checks++;
      if (req_ack !== 4'b0010) begin
         failures++;
         $display("FAIL reset_regrant_ack: got %b expected 0010", req_ack);
      end
      req_vld = '0;
      tick();
      tick();              // cycle 3: CAPT
      checks++;
      if (rsp_vld !== 1'b0) begin
         failures++;
         $display("FAIL reset_rsp_early: got %b expected 0", rsp_vld);
      end
      tick();              // cycle 4: RESP
      checks++;
      if ({rsp_vld, rsp_tid, rsp_data} !== {1'b1, 2'd1, 64'h0123_4567_89AB_CDEF}) begin
         failures++;
         $display("FAIL reset_regrant_rsp: got %b/%0d/%h expected 1/1/0123456789abcdef",
                  rsp_vld, rsp_tid, rsp_data);
      end
      tick();
   endtask

   task automatic test_single_tag();
      do_reset();
      set_req(2, 6'h15, 2'b00);
      req_vld = 4'b0100;
      tick();              // cycle 1
      checks++;
      if ({rd_vld, rd_idx, req_ack} !== {1'b1, 6'h15, 4'b0100}) begin
         failures++;
         $display("FAIL tag_rd_cycle: got vld=%b idx=%h ack=%b expected 1/15/0100",
                  rd_vld, rd_idx, req_ack);
      end
      req_vld = '0;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) rd_data = 64'h1111_2222_3333_4444;
         if (c == 3) rd_data = 64'hDEAD_BEEF_0123_4567;
         checks++;
         if ({data_sel, csm_sel} !== 2'b00) begin
            failures++;
            $display("FAIL tag_selects c%0d: got %b expected 00", c, {data_sel, csm_sel});
         end
         if (c == 3) begin
            checks++;
            if (rsp_vld !== 1'b0) begin
               failures++;
               $display("FAIL tag_rsp_early: got %b expected 0", rsp_vld);
            end
         end
         if (c < 3) tick();
      end
      tick();              // cycle 4
      rd_data = 64'h5555_6666_7777_8888;
      checks++;
      if ({rsp_vld, rsp_tid, rsp_data, rsp_perr} !==
          {1'b1, 2'd2, 64'hDEAD_BEEF_0123_4567, 1'b0}) begin
         failures++;
         $display("FAIL tag_rsp: got %b/%0d/%h/%b expected 1/2/deadbeef01234567/0",
                  rsp_vld, rsp_tid, rsp_data, rsp_perr);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int exp_t;
      do_reset();
      for (int t = 0; t < 4; t++) set_req(t, 6'(t + 8), 2'b01);
      req_vld = 4'hF;
      for (int g = 0; g < 5; g++) begin
         exp_t = g % 4;
         for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
               checks++;
               if ({req_ack, rd_idx} !== {4'(1 << exp_t), 6'(exp_t + 8)}) begin
                  failures++;
                  $display("FAIL rr_grant g%0d: got ack=%b idx=%h expected thread %0d",
                           g, req_ack, rd_idx, exp_t);
               end
            end
            checks++;
            if ({data_sel, csm_sel} !== ((c <= 3) ? 2'b10 : 2'b00)) begin
               failures++;
               $display("FAIL rr_data_sel g%0d c%0d: got %b", g, c, {data_sel, csm_sel});
            end
            if (c == 4) begin
               checks++;
               if ({rsp_vld, rsp_tid} !== {1'b1, 2'(exp_t)}) begin
                  failures++;
                  $display("FAIL rr_rsp g%0d: got %b/%0d expected 1/%0d",
                           g, rsp_vld, rsp_tid, exp_t);
               end
            end
         end
      end
      req_vld = '0;
      tick();
      tick();
      tick();
      tick();
   endtask

   task automatic test_parity();
      do_reset();
      set_req(3, 6'h01, 2'b01);
      req_vld = 4'b1000;
      tick();              // cycle 1
      req_vld = '0;
      tick();
      tick();              // cycle 3: CAPT
      data_err = 1'b1;
      tick();              // cycle 4
      data_err = 1'b0;
      checks++;
      if ({rsp_vld, rsp_perr} !== 2'b11) begin
         failures++;
         $display("FAIL perr_data: got vld=%b perr=%b expected 1/1", rsp_vld, rsp_perr);
      end
      tick();              // IDLE
      set_req(0, 6'h02, 2'b10);
      req_vld = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 1) req_vld = '0;
         if (c == 3) begin
            tag_err  = 1'b1;
            data_err = 1'b1;
         end
         checks++;
         if ({data_sel, csm_sel} !== 2'b01) begin
            failures++;
            $display("FAIL perr_csm_sel c%0d: got %b expected 01", c, {data_sel, csm_sel});
         end
      end
      tick();              // cycle 4
      tag_err  = 1'b0;
      data_err = 1'b0;
      checks++;
      if ({rsp_vld, rsp_tid, rsp_perr, csm_sel} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL perr_csm: got vld=%b tid=%0d perr=%b sel=%b expected 1/0/0/0",
                  rsp_vld, rsp_tid, rsp_perr, csm_sel);
      end
      tick();
   endtask

   task automatic test_backpressure_stall();
      do_reset();
      rsp_rdy = 1'b0;
      set_req(1, 6'h05, 2'b00);
      set_req(0, 6'h33, 2'b00);
      rd_data = 64'hA5A5_5A5A_0F0F_F0F0;
      req_vld = 4'b0010;
      tick();              // cycle 1
      req_vld = 4'b0001;   // thread 0 queues behind the busy FSM
      tick();
      tick();
      tick();              // cycle 4: RESP
      for (int i = 0; i < 5; i++) begin
         rd_data = 64'(i) * 64'h1010_1010_1010_1010;
         checks++;
         if ({rsp_vld, rsp_data, rd_vld, req_ack} !==
             {1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL bp_hold c%0d: got vld=%b data=%h strobe=%b ack=%b",
                     i + 4, rsp_vld, rsp_data, rd_vld, req_ack);
         end
         if (i < 4) tick();
      end
      rsp_rdy = 1'b1;
      tick();              // IDLE
      checks++;
      if (rsp_vld !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: got rsp_vld=%b expected 0", rsp_vld);
      end
      tick();
      checks++;
      if ({req_ack, rd_vld, rd_idx} !== {4'b0001, 1'b1, 6'h33}) begin
         failures++;
         $display("FAIL bp_next_grant: got ack=%b vld=%b idx=%h expected 0001/1/33",
                  req_ack, rd_vld, rd_idx);
      end
      req_vld = '0;
      tick();
      tick();
      tick();
      tick();              // IDLE
      stall   = 1'b1;
      req_vld = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({req_ack, rd_vld} !== 5'b0) begin
            failures++;
            $display("FAIL stall_hold c%0d: got ack=%b vld=%b expected 0", i, req_ack, rd_vld);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({req_ack, rd_vld} !== {4'b0001, 1'b1}) begin
         failures++;
         $display("FAIL stall_release: got ack=%b vld=%b expected 0001/1", req_ack, rd_vld);
      end
      req_vld = '0;
      tick();
      tick();
      tick();
      tick();
   endtask

   task automatic test_rd_lat1();
      do_reset();
      set_req(2, 6'h07, 2'b00);
      req_vld = 4'b0100;
      tick();              // cycle 1
      checks++;
      if ({d1_req_ack, d1_rd_vld, d1_rd_idx} !== {4'b0100, 1'b1, 6'h07}) begin
         failures++;
         $display("FAIL lat1_rd: got ack=%b vld=%b idx=%h expected 0100/1/07",
                  d1_req_ack, d1_rd_vld, d1_rd_idx);
      end
      req_vld = '0;
      tick();              // cycle 2: CAPT
      rd_data = 64'hCAFE_F00D_1234_5678;
      checks++;
      if (d1_rsp_vld !== 1'b0) begin
         failures++;
         $display("FAIL lat1_rsp_early: got %b expected 0", d1_rsp_vld);
      end
      tick();              // cycle 3
      rd_data = '0;
      checks++;
      if ({d1_rsp_vld, d1_rsp_tid, d1_rsp_data} !== {1'b1, 2'd2, 64'hCAFE_F00D_1234_5678}) begin
         failures++;
         $display("FAIL lat1_rsp: got %b/%0d/%h expected 1/2/cafef00d12345678",
                  d1_rsp_vld, d1_rsp_tid, d1_rsp_data);
      end
      tick();
      tick();
   endtask

   task automatic test_type11();
      do_reset();
      set_req(1, 6'h3F, 2'b11);
      req_vld = 4'b0010;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 1) req_vld = '0;
         if (c == 3) tag_err = 1'b1;
         checks++;
         if ({data_sel, csm_sel} !== 2'b00) begin
            failures++;
            $display("FAIL t11_selects c%0d: got %b expected 00", c, {data_sel, csm_sel});
         end
      end
      tick();              // cycle 4
      tag_err = 1'b0;
      checks++;
      if ({rsp_vld, rsp_perr} !== 2'b11) begin
         failures++;
         $display("FAIL t11_perr: got vld=%b perr=%b expected 1/1", rsp_vld, rsp_perr);
      end
      tick();
   endtask

   initial begin
      rst_l = 1'b0;
      test_reset();
      test_single_tag();
      test_round_robin();
      test_parity();
      test_backpressure_stall();
      test_rd_lat1();
      test_type11();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
